// File: rtl/change_dispenser.sv
// Change dispenser FSM: pays out owed nickels as quarter/dime/nickel pulses, largest coin first.
// Optional coin-tube inventory with short-change reporting when CHANGE_INVENTORY_EN is defined.
`timescale 1ns/1ps
module change_dispenser (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] amount,
    input  logic       eject_ack,
`ifdef CHANGE_INVENTORY_EN
    input  logic       load,
    input  logic [3:0] load_q,
    input  logic [3:0] load_d,
    input  logic [3:0] load_n,
    output logic       short_chg,
`endif
    output logic       N_out,
    output logic       D_out,
    output logic       Q_out,
    output logic       busy,
    output logic       done,
    output logic [4:0] remaining
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SELECT = 2'd1;
    localparam logic [1:0] EJECT  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0] state_q, state_d;
    logic [4:0] rem_d;
    logic       n_d, d_d, q_d, busy_d, done_d;
    logic       q_ok, d_ok, n_ok;

`ifdef CHANGE_INVENTORY_EN
    localparam logic [1:0] COIN_N = 2'd0;
    localparam logic [1:0] COIN_D = 2'd1;
    localparam logic [1:0] COIN_Q = 2'd2;

    logic [3:0] qcnt_q, qcnt_d, dcnt_q, dcnt_d, ncnt_q, ncnt_d;
    logic [1:0] last_q, last_d;
    logic       short_d;

    assign q_ok = (remaining >= 5'd5) && (qcnt_q != 4'd0);
    assign d_ok = (remaining >= 5'd2) && (dcnt_q != 4'd0);
    assign n_ok = (remaining != 5'd0) && (ncnt_q != 4'd0);
`else
    assign q_ok = (remaining >= 5'd5);
    assign d_ok = (remaining >= 5'd2);
    assign n_ok = (remaining != 5'd0);
`endif

    always_comb begin
        state_d = state_q;
        rem_d   = remaining;
        n_d     = 1'b0;
        d_d     = 1'b0;
        q_d     = 1'b0;
        done_d  = 1'b0;
`ifdef CHANGE_INVENTORY_EN
        qcnt_d  = qcnt_q;
        dcnt_d  = dcnt_q;
        ncnt_d  = ncnt_q;
        last_d  = last_q;
        short_d = short_chg;
`endif
        case (state_q)
            IDLE: begin
`ifdef CHANGE_INVENTORY_EN
                if (load) begin
                    qcnt_d = load_q;
                    dcnt_d = load_d;
                    ncnt_d = load_n;
                end
`endif
                if (start) begin
                    rem_d   = amount;
                    state_d = (amount == 5'd0) ? DONE : SELECT;
`ifdef CHANGE_INVENTORY_EN
                    short_d = 1'b0;
`endif
                end
            end
            SELECT: begin
                if (q_ok) begin
                    q_d     = 1'b1;
                    rem_d   = remaining - 5'd5;
                    state_d = EJECT;
`ifdef CHANGE_INVENTORY_EN
                    last_d  = COIN_Q;
`endif
                end else if (d_ok) begin
                    d_d     = 1'b1;
                    rem_d   = remaining - 5'd2;
                    state_d = EJECT;
`ifdef CHANGE_INVENTORY_EN
                    last_d  = COIN_D;
`endif
                end else if (n_ok) begin
                    n_d     = 1'b1;
                    rem_d   = remaining - 5'd1;
                    state_d = EJECT;
`ifdef CHANGE_INVENTORY_EN
                    last_d  = COIN_N;
`endif
                end else begin
                    // No eligible coin: give up and keep the owed amount visible.
                    state_d = DONE;
`ifdef CHANGE_INVENTORY_EN
                    short_d = 1'b1;
`endif
                end
            end
            EJECT: begin
                if (eject_ack) begin
                    state_d = (remaining == 5'd0) ? DONE : SELECT;
`ifdef CHANGE_INVENTORY_EN
                    if (last_q == COIN_Q && qcnt_q != 4'd0) qcnt_d = qcnt_q - 4'd1;
                    if (last_q == COIN_D && dcnt_q != 4'd0) dcnt_d = dcnt_q - 4'd1;
                    if (last_q == COIN_N && ncnt_q != 4'd0) ncnt_d = ncnt_q - 4'd1;
`endif
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            remaining <= 5'd0;
            N_out     <= 1'b0;
            D_out     <= 1'b0;
            Q_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            remaining <= rem_d;
            N_out     <= n_d;
            D_out     <= d_d;
            Q_out     <= q_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

`ifdef CHANGE_INVENTORY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qcnt_q    <= 4'd0;
            dcnt_q    <= 4'd0;
            ncnt_q    <= 4'd0;
            last_q    <= COIN_N;
            short_chg <= 1'b0;
        end else begin
            qcnt_q    <= qcnt_d;
            dcnt_q    <= dcnt_d;
            ncnt_q    <= ncnt_d;
            last_q    <= last_d;
            short_chg <= short_d;
        end
    end
`endif

endmodule
